// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the register file.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;
    localparam int CNT_W      = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// Per-read-port forwarding mux: substitutes in-flight write data on an index match.
module reg_file_bypass
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              fwd_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] arr_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    // fwd_en_i already excludes index 0 and reset, so only the address match remains.
    assign rd_data_o = (fwd_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : arr_data_i;

endmodule

// File: rtl/reg_file.sv
// Two-read / one-write register file with hardwired zero register and a saturating write counter.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] src_data,
    output logic [DATA_W-1:0] tar_data,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  write_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              commit;
    logic [DATA_W-1:0] arr_rs, arr_rt;

    assign commit = reg_write && (rd_addr != ZERO_IDX);

    always_comb begin
        cnt_d = cnt_q;
        if (commit) cnt_d = sat_inc(cnt_q);
    end

    // Reset wins over a simultaneous write; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            cnt_q <= '0;
        end else begin
            if (commit) regs_q[rd_addr] <= rd_data;
            cnt_q <= cnt_d;
        end
    end

    assign arr_rs    = (rs_addr == ZERO_IDX) ? '0 : regs_q[rs_addr];
    assign arr_rt    = (rt_addr == ZERO_IDX) ? '0 : regs_q[rt_addr];
    assign write_cnt = cnt_q;

`ifdef REG_FILE_BYPASS_EN
    logic fwd_en;
    assign fwd_en = commit && rst_n;

    reg_file_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_rs (
        .fwd_en_i   (fwd_en),
        .wr_addr_i  (rd_addr),
        .wr_data_i  (rd_data),
        .rd_addr_i  (rs_addr),
        .arr_data_i (arr_rs),
        .rd_data_o  (src_data)
    );

    reg_file_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_rt (
        .fwd_en_i   (fwd_en),
        .wr_addr_i  (rd_addr),
        .wr_data_i  (rd_data),
        .rd_addr_i  (rt_addr),
        .arr_data_i (arr_rt),
        .rd_data_o  (tar_data)
    );
`else
    assign src_data = arr_rs;
    assign tar_data = arr_rt;
`endif

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file with a queue scoreboard of expected read/counter values.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [31:0] src_data, tar_data, rd_data;
    logic        reg_write;
    logic [15:0] write_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .src_data  (src_data),
        .tar_data  (tar_data),
        .reg_write (reg_write),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .write_cnt (write_cnt)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val)
            else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance one rising edge, then settle inputs/outputs away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_write = 1'b1;
        rd_addr   = a;
        rd_data   = d;
        tick();
        reg_write = 1'b0;
    endtask

    logic [31:0] hazard_same;

    initial begin
        rst_n = 1'b0; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
        rs_addr = 5'd5; rt_addr = 5'd0;
        tick();
        expect_val("reset_cnt", 32'd0);  check({16'd0, write_cnt});
        expect_val("reset_read", 32'd0); check(src_data);
        rst_n = 1'b1;
        tick();

        // Preload then reset clear
        wr(5'd5, 32'hDEADBEEF);
        expect_val("preload_read", 32'hDEADBEEF); check(src_data);
        expect_val("preload_cnt", 32'd1);         check({16'd0, write_cnt});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_val("clear_read", 32'd0); check(src_data);
        expect_val("clear_cnt", 32'd0);  check({16'd0, write_cnt});

        // Basic write / read on both ports
        wr(5'd3, 32'h0000_0010);
        wr(5'd4, 32'h0000_0003);
        rs_addr = 5'd3; rt_addr = 5'd4; #1;
        expect_val("wr_src", 32'd16); check(src_data);
        expect_val("wr_tar", 32'd3);  check(tar_data);
        expect_val("wr_cnt", 32'd2);  check({16'd0, write_cnt});

        // Zero register discards writes
        wr(5'd0, 32'hFFFF_FFFF);
        rs_addr = 5'd0; rt_addr = 5'd0; #1;
        expect_val("zero_src", 32'd0); check(src_data);
        expect_val("zero_tar", 32'd0); check(tar_data);
        expect_val("zero_cnt", 32'd2); check({16'd0, write_cnt});

        // Both ports on the same register
        rs_addr = 5'd4; rt_addr = 5'd4; #1;
        expect_val("same_src", 32'd3); check(src_data);
        expect_val("same_tar", 32'd3); check(tar_data);

        // Same-cycle write/read hazard
        wr(5'd7, 32'd1);
        rs_addr = 5'd7; reg_write = 1'b1; rd_addr = 5'd7; rd_data = 32'd2; #1;
`ifdef REG_FILE_BYPASS_EN
        hazard_same = 32'd2;
`else
        hazard_same = 32'd1;
`endif
        expect_val("hazard_same_cycle", hazard_same); check(src_data);
        tick();
        reg_write = 1'b0; #1;
        expect_val("hazard_next_cycle", 32'd2); check(src_data);
        expect_val("hazard_cnt", 32'd4);        check({16'd0, write_cnt});

        // reg_write=0 leaves state alone
        rd_addr = 5'd3; rd_data = 32'hBAD0_BAD0; rs_addr = 5'd3;
        tick();
        expect_val("nowrite_read", 32'd16); check(src_data);
        expect_val("nowrite_cnt", 32'd4);   check({16'd0, write_cnt});

        // Reset beats a simultaneous write; no forwarding during reset
        rst_n = 1'b0; reg_write = 1'b1; rd_addr = 5'd9; rd_data = 32'h55; rs_addr = 5'd9; #1;
        expect_val("rst_no_bypass", 32'd0); check(src_data);
        tick();
        reg_write = 1'b0; #1;
        expect_val("rst_prio_read", 32'd0); check(src_data);
        expect_val("rst_prio_cnt", 32'd0);  check({16'd0, write_cnt});
        rst_n = 1'b1;
        wr(5'd9, 32'h77);
        expect_val("post_rst_write", 32'h77); check(src_data);
        expect_val("post_rst_cnt", 32'd1);    check({16'd0, write_cnt});

        // Saturation: 65540 writes to reg[1] on top of count 1
        rs_addr = 5'd1;
        for (int i = 0; i < 65533; i++) wr(5'd1, 32'(i));
        expect_val("sat_before", 32'h0000_FFFE); check({16'd0, write_cnt});
        wr(5'd1, 32'hA5A5_0001);
        expect_val("sat_reach", 32'h0000_FFFF); check({16'd0, write_cnt});
        for (int i = 0; i < 6; i++) wr(5'd1, 32'hC000_0000 + 32'(i));
        expect_val("sat_hold", 32'h0000_FFFF); check({16'd0, write_cnt});
        expect_val("sat_data", 32'hC000_0005); check(src_data);

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
- REQ-001 Parameter DATA_W, default 32, register and port data width.
- REQ-002 Parameter ADDR_W, default 5, register index width; depth is 2**ADDR_W (32).
- REQ-003 clk  input  1  single clock; all state updates on the rising edge.
- REQ-004 rst_n  input  1  reset, synchronous, active-low.
- REQ-005 rs_addr  input  ADDR_W  read port A index.
- REQ-006 rt_addr  input  ADDR_W  read port B index.
- REQ-007 src_data  output  DATA_W  port A read data; drives the ALU source operand.
- REQ-008 tar_data  output  DATA_W  port B read data; drives the ALU target operand.
- REQ-009 reg_write  input  1  write enable.
- REQ-010 rd_addr  input  ADDR_W  write index.
- REQ-011 rd_data  input  DATA_W  write data, normally the ALU data_out.
- REQ-012 write_cnt  output  16  count of committed writes, saturating.

Function
- REQ-013 Storage SHALL be an array of 2**ADDR_W registers, each DATA_W bits wide.
- REQ-014 Reads SHALL be combinational:
  - src_data = reg[rs_addr];
  - tar_data = reg[rt_addr];
  - zero-cycle latency.
- REQ-015 When reg_write=1 and rd_addr!=0 at a rising edge, reg[rd_addr] SHALL take rd_data, visible on the read ports from the next cycle.
- REQ-016 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded and SHALL NOT increment write_cnt.
- REQ-017 write_cnt SHALL increment by 1 per committed write (REQ-015) and hold at 16'hFFFF once reached.
- REQ-018 Both read ports addressing the same register SHALL return identical data.
- REQ-019 A write and a read of the same index in the same cycle, with bypass compiled out, SHALL return the old value that cycle.
- REQ-020 reg_write=0 SHALL leave all registers and write_cnt unchanged.

Reset
- REQ-021 When rst_n=0 at a rising edge, all registers and write_cnt SHALL be cleared to 0, overriding any simultaneous write.
- REQ-022 During reset, src_data and tar_data SHALL reflect the array contents, which are 0 after the first reset edge.
- REQ-023 When reset is asserted mid-operation, no partial write SHALL survive; the first write SHALL be accepted on the first edge with rst_n=1.

Configuration
- REQ-024 Macro REG_FILE_BYPASS_EN SHALL control write-to-read forwarding.
  - Defined: when reg_write=1, rd_addr!=0 and rd_addr equals rs_addr (or rt_addr), that port SHALL output rd_data combinationally in the same cycle.
  - Undefined: REQ-019 behaviour.
- REQ-025 Bypass SHALL NOT apply to index 0, and SHALL NOT apply while rst_n=0.

Structure
- REQ-026 A shared package SHALL hold:
  - DATA_W and ADDR_W defaults;
  - the ZERO_REG index constant (0);
  - the write_cnt width constant (16).
- REQ-027 Sub-module reg_file_bypass SHALL implement the per-port forwarding mux, instantiated once per read port and only when REG_FILE_BYPASS_EN is defined.

Verification
- REQ-028 Reset clear: preload reg[5]=32'hDEADBEEF, pulse rst_n=0 for one edge -> rs_addr=5 reads 0 and write_cnt=0.
- REQ-029 Write/read: write reg[3]=32'h0000_0010 and reg[4]=32'h0000_0003 -> next cycle rs_addr=3, rt_addr=4 give src_data=16, tar_data=3, write_cnt=2.
- REQ-030 Zero register: reg_write=1, rd_addr=0, rd_data=32'hFFFF_FFFF -> reg[0] reads 0 and write_cnt is unchanged.
- REQ-031 Same-cycle hazard: reg[7]=1, then write reg[7]=2 while rs_addr=7 ->
  - same cycle reads 2 with REG_FILE_BYPASS_EN defined, 1 without;
  - next cycle reads 2 in both builds.
- REQ-032 Reset priority: rst_n=0 with reg_write=1, rd_addr=9, rd_data=32'h55 -> reg[9]=0 after the edge.
- REQ-033 Saturation: 65,540 writes to reg[1] -> write_cnt=16'hFFFF and holds.
